// File: rtl/gelato_inst_fetch_pipe.sv
// Pipelined instruction fetch stage: credit-limited I-cache requests with in-order delivery of
// instructions plus their warp/split metadata; flush drops queued and in-flight work.
module gelato_inst_fetch_pipe #(
  parameter int unsigned PC_WIDTH        = 32,
  parameter int unsigned INST_WIDTH      = 32,
  parameter int unsigned WARP_NUM_WIDTH  = 5,
  parameter int unsigned SPLIT_NUM_WIDTH = 4,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               rdy,
  input  logic                               flush,
  input  logic                               pc_valid,
  output logic                               pc_ready,
  input  logic [PC_WIDTH-1:0]                pc,
  input  logic [WARP_NUM_WIDTH-1:0]          pc_warp_num,
  input  logic [SPLIT_NUM_WIDTH-1:0]         pc_split_table_num,
  output logic                               mem_req_valid,
  input  logic                               mem_req_ready,
  output logic [PC_WIDTH-1:0]                mem_req_addr,
  input  logic                               mem_rsp_valid,
  input  logic [INST_WIDTH-1:0]              mem_rsp_data,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [PC_WIDTH-1:0]                out_pc,
  output logic [WARP_NUM_WIDTH-1:0]          out_warp_num,
  output logic [SPLIT_NUM_WIDTH-1:0]         out_split_table_num,
  output logic [INST_WIDTH-1:0]              out_inst,
  output logic [$clog2(MAX_OUTSTANDING):0]   outstanding
);

  localparam int unsigned AW = $clog2(MAX_OUTSTANDING);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW:0] DepthU = (CW + 1)'(MAX_OUTSTANDING);

  logic [PC_WIDTH-1:0]        meta_pc_q    [MAX_OUTSTANDING];
  logic [WARP_NUM_WIDTH-1:0]  meta_warp_q  [MAX_OUTSTANDING];
  logic [SPLIT_NUM_WIDTH-1:0] meta_split_q [MAX_OUTSTANDING];
  logic [INST_WIDTH-1:0]      data_q       [MAX_OUTSTANDING];

  logic [AW-1:0] meta_wptr_q, meta_wptr_d, meta_rptr_q, meta_rptr_d;
  logic [AW-1:0] data_wptr_q, data_wptr_d, data_rptr_q, data_rptr_d;
  logic [CW-1:0] meta_cnt_q, meta_cnt_d, data_cnt_q, data_cnt_d;
  logic [CW-1:0] drop_cnt_q, drop_cnt_d, pend_cnt_q, pend_cnt_d;
  logic          mem_req_valid_q, mem_req_valid_d;
  logic [PC_WIDTH-1:0] mem_req_addr_q, mem_req_addr_d;

  logic [CW:0] used;
  logic        acc, xfer, pop, rsp_keep;

  assign used     = {1'b0, meta_cnt_q} + {1'b0, drop_cnt_q};
  assign pc_ready = !rst && !flush && rdy && (used < DepthU) &&
                    (!mem_req_valid_q || mem_req_ready);
  assign acc      = pc_valid && pc_ready;
  assign xfer     = mem_req_valid_q && mem_req_ready && rdy;
  assign pop      = out_valid && out_ready && rdy && !flush;
  // A response landing in the flush cycle is accounted for in drop_cnt_d instead.
  assign rsp_keep = mem_rsp_valid && (drop_cnt_q == '0) && !flush;

  assign outstanding         = used[CW-1:0];
  assign mem_req_valid       = mem_req_valid_q;
  assign mem_req_addr        = mem_req_addr_q;
  assign out_valid           = (data_cnt_q != '0);
  assign out_pc              = meta_pc_q[meta_rptr_q];
  assign out_warp_num        = meta_warp_q[meta_rptr_q];
  assign out_split_table_num = meta_split_q[meta_rptr_q];
  assign out_inst            = data_q[data_rptr_q];

  always_comb begin
    meta_wptr_d     = meta_wptr_q;
    meta_rptr_d     = meta_rptr_q;
    meta_cnt_d      = meta_cnt_q;
    data_wptr_d     = data_wptr_q;
    data_rptr_d     = data_rptr_q;
    data_cnt_d      = data_cnt_q;
    drop_cnt_d      = drop_cnt_q;
    mem_req_valid_d = mem_req_valid_q;
    mem_req_addr_d  = mem_req_addr_q;
    pend_cnt_d      = pend_cnt_q + CW'(xfer) - CW'(mem_rsp_valid);

    if (flush) begin
      meta_wptr_d = '0;
      meta_rptr_d = '0;
      meta_cnt_d  = '0;
      data_wptr_d = '0;
      data_rptr_d = '0;
      data_cnt_d  = '0;
      // Every request still awaiting a response after this cycle becomes a drop.
      drop_cnt_d  = pend_cnt_d;
    end else begin
      if (acc) meta_wptr_d = meta_wptr_q + 1'b1;
      if (pop) meta_rptr_d = meta_rptr_q + 1'b1;
      meta_cnt_d = meta_cnt_q + CW'(acc) - CW'(pop);
      if (rsp_keep) data_wptr_d = data_wptr_q + 1'b1;
      if (pop) data_rptr_d = data_rptr_q + 1'b1;
      data_cnt_d = data_cnt_q + CW'(rsp_keep) - CW'(pop);
      if (mem_rsp_valid && (drop_cnt_q != '0)) drop_cnt_d = drop_cnt_q - 1'b1;
    end

    if (flush) begin
      mem_req_valid_d = 1'b0;
    end else if (acc) begin
      mem_req_valid_d = 1'b1;
    end else if (xfer) begin
      mem_req_valid_d = 1'b0;
    end
    if (acc) mem_req_addr_d = pc;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_wptr_q     <= '0;
      meta_rptr_q     <= '0;
      meta_cnt_q      <= '0;
      data_wptr_q     <= '0;
      data_rptr_q     <= '0;
      data_cnt_q      <= '0;
      drop_cnt_q      <= '0;
      pend_cnt_q      <= '0;
      mem_req_valid_q <= 1'b0;
      mem_req_addr_q  <= '0;
      for (int i = 0; i < int'(MAX_OUTSTANDING); i++) begin
        meta_pc_q[i]    <= '0;
        meta_warp_q[i]  <= '0;
        meta_split_q[i] <= '0;
        data_q[i]       <= '0;
      end
    end else begin
      meta_wptr_q     <= meta_wptr_d;
      meta_rptr_q     <= meta_rptr_d;
      meta_cnt_q      <= meta_cnt_d;
      data_wptr_q     <= data_wptr_d;
      data_rptr_q     <= data_rptr_d;
      data_cnt_q      <= data_cnt_d;
      drop_cnt_q      <= drop_cnt_d;
      pend_cnt_q      <= pend_cnt_d;
      mem_req_valid_q <= mem_req_valid_d;
      mem_req_addr_q  <= mem_req_addr_d;
      if (acc) begin
        meta_pc_q[meta_wptr_q]    <= pc;
        meta_warp_q[meta_wptr_q]  <= pc_warp_num;
        meta_split_q[meta_wptr_q] <= pc_split_table_num;
      end
      if (rsp_keep) data_q[data_wptr_q] <= mem_rsp_data;
    end
  end

`ifndef SYNTHESIS
  rsp_has_request: assert property (@(posedge clk) disable iff (rst)
    mem_rsp_valid |-> (pend_cnt_q != '0))
    else $error("response received with no request outstanding");
`endif

endmodule

// File: tb/tb_gelato_inst_fetch_pipe.sv
// Directed bench for gelato_inst_fetch_pipe: per-cycle vector table plus hand-written sequences
// for backpressure, flush, rdy stall and asynchronous reset.
module tb_gelato_inst_fetch_pipe;

  logic        clk = 1'b0;
  logic        rst, rdy, flush, pc_valid, pc_ready;
  logic [31:0] pc;
  logic [4:0]  pc_warp_num;
  logic [3:0]  pc_split_table_num;
  logic        mem_req_valid, mem_req_ready, mem_rsp_valid;
  logic [31:0] mem_req_addr, mem_rsp_data;
  logic        out_valid, out_ready;
  logic [31:0] out_pc, out_inst;
  logic [4:0]  out_warp_num;
  logic [3:0]  out_split_table_num;
  logic [2:0]  outstanding;

  int n_pass = 0;
  int n_tot  = 0;

  gelato_inst_fetch_pipe dut (
    .clk                 (clk),
    .rst                 (rst),
    .rdy                 (rdy),
    .flush               (flush),
    .pc_valid            (pc_valid),
    .pc_ready            (pc_ready),
    .pc                  (pc),
    .pc_warp_num         (pc_warp_num),
    .pc_split_table_num  (pc_split_table_num),
    .mem_req_valid       (mem_req_valid),
    .mem_req_ready       (mem_req_ready),
    .mem_req_addr        (mem_req_addr),
    .mem_rsp_valid       (mem_rsp_valid),
    .mem_rsp_data        (mem_rsp_data),
    .out_valid           (out_valid),
    .out_ready           (out_ready),
    .out_pc              (out_pc),
    .out_warp_num        (out_warp_num),
    .out_split_table_num (out_split_table_num),
    .out_inst            (out_inst),
    .outstanding         (outstanding)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        pv;
    logic [31:0] pc;
    logic [4:0]  w;
    logic [3:0]  s;
    logic        mrr;
    logic        rv;
    logic [31:0] rd;
    logic        ordy;
    logic        e_pr;
    logic        e_mrv;
    logic [31:0] e_addr;
    logic        e_ov;
    logic [31:0] e_opc;
    logic [4:0]  e_ow;
    logic [3:0]  e_os;
    logic [31:0] e_inst;
    logic [2:0]  e_ost;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(input logic pv_, input logic [31:0] pc_, input logic [4:0] w_,
                             input logic [3:0] s_, input logic mrr_, input logic rv_,
                             input logic [31:0] rd_, input logic ordy_, input logic epr,
                             input logic emrv, input logic [31:0] eaddr, input logic eov,
                             input logic [31:0] eopc, input logic [4:0] ew, input logic [3:0] es,
                             input logic [31:0] einst, input logic [2:0] eost);
    vec_t r;
    r.pv = pv_; r.pc = pc_; r.w = w_; r.s = s_; r.mrr = mrr_; r.rv = rv_; r.rd = rd_;
    r.ordy = ordy_; r.e_pr = epr; r.e_mrv = emrv; r.e_addr = eaddr; r.e_ov = eov;
    r.e_opc = eopc; r.e_ow = ew; r.e_os = es; r.e_inst = einst; r.e_ost = eost;
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // Advance one clock, then drive this cycle's inputs and let them settle before checking.
  task automatic cycle_in(input logic pv_, input logic [31:0] pc_, input logic [4:0] w_,
                          input logic [3:0] s_, input logic mrr_, input logic rv_,
                          input logic [31:0] rd_, input logic ordy_, input logic fl_,
                          input logic rdy_);
    @(posedge clk);
    #1;
    pc_valid = pv_; pc = pc_; pc_warp_num = w_; pc_split_table_num = s_;
    mem_req_ready = mrr_; mem_rsp_valid = rv_; mem_rsp_data = rd_; out_ready = ordy_;
    flush = fl_; rdy = rdy_;
    #1;
  endtask

  task automatic idle(input logic rv_, input logic [31:0] rd_, input logic ordy_);
    cycle_in(1'b0, 32'h0, 5'd0, 4'd0, 1'b1, rv_, rd_, ordy_, 1'b0, 1'b1);
  endtask

  task automatic chk_head(input string name, input logic [31:0] epc, input logic [4:0] ew,
                          input logic [3:0] es, input logic [31:0] einst);
    chk({name, ".out_valid"}, out_valid, 1'b1);
    chk({name, ".out_pc"}, out_pc, epc);
    chk({name, ".out_warp"}, out_warp_num, ew);
    chk({name, ".out_split"}, out_split_table_num, es);
    chk({name, ".out_inst"}, out_inst, einst);
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, ".pc_ready"}, pc_ready, 1'b0);
    chk({name, ".mem_req_valid"}, mem_req_valid, 1'b0);
    chk({name, ".mem_req_addr"}, mem_req_addr, 32'h0);
    chk({name, ".out_valid"}, out_valid, 1'b0);
    chk({name, ".out_pc"}, out_pc, 32'h0);
    chk({name, ".out_warp"}, out_warp_num, 5'd0);
    chk({name, ".out_split"}, out_split_table_num, 4'd0);
    chk({name, ".out_inst"}, out_inst, 32'h0);
    chk({name, ".outstanding"}, outstanding, 3'd0);
  endtask

  initial begin
    rst = 1'b1; rdy = 1'b1; flush = 1'b0; pc_valid = 1'b0; pc = '0; pc_warp_num = '0;
    pc_split_table_num = '0; mem_req_ready = 1'b1; mem_rsp_valid = 1'b0; mem_rsp_data = '0;
    out_ready = 1'b0;

    // Single fetch
    tbl.push_back(v(1, 32'h100, 3, 1, 1, 0, 0, 0,  1, 0, 0,       0, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, 0, 0, 0, 1, 0, 0, 0,        1, 1, 32'h100, 0, 0, 0, 0, 0, 1));
    tbl.push_back(v(0, 0, 0, 0, 1, 0, 0, 0,        1, 0, 0,       0, 0, 0, 0, 0, 1));
    tbl.push_back(v(0, 0, 0, 0, 1, 1, 32'hDEADBEEF, 0, 1, 0, 0,   0, 0, 0, 0, 0, 1));
    tbl.push_back(v(0, 0, 0, 0, 1, 0, 0, 0,  1, 0, 0, 1, 32'h100, 3, 1, 32'hDEADBEEF, 1));
    tbl.push_back(v(0, 0, 0, 0, 1, 0, 0, 1,  1, 0, 0, 1, 32'h100, 3, 1, 32'hDEADBEEF, 1));
    tbl.push_back(v(0, 0, 0, 0, 1, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0, 0, 0));
    // Saturation: six offers, four accepted, one pop frees exactly one credit
    tbl.push_back(v(1, 32'h200, 4, 2, 1, 0, 0, 0,  1, 0, 0,       0, 0, 0, 0, 0, 0));
    tbl.push_back(v(1, 32'h204, 5, 2, 1, 0, 0, 0,  1, 1, 32'h200, 0, 0, 0, 0, 0, 1));
    tbl.push_back(v(1, 32'h208, 6, 2, 1, 1, 32'hA0000000, 0, 1, 1, 32'h204, 0, 0, 0, 0, 0, 2));
    tbl.push_back(v(1, 32'h20C, 7, 2, 1, 1, 32'hA0000001, 0, 1, 1, 32'h208,
                    1, 32'h200, 4, 2, 32'hA0000000, 3));
    tbl.push_back(v(1, 32'h210, 8, 2, 1, 1, 32'hA0000002, 0, 0, 1, 32'h20C,
                    1, 32'h200, 4, 2, 32'hA0000000, 4));
    tbl.push_back(v(1, 32'h214, 9, 2, 1, 1, 32'hA0000003, 0, 0, 0, 0,
                    1, 32'h200, 4, 2, 32'hA0000000, 4));
    tbl.push_back(v(1, 32'h210, 8, 2, 1, 0, 0, 1,  0, 0, 0, 1, 32'h200, 4, 2, 32'hA0000000, 4));
    tbl.push_back(v(1, 32'h210, 8, 2, 1, 0, 0, 0,  1, 0, 0, 1, 32'h204, 5, 2, 32'hA0000001, 3));
    tbl.push_back(v(0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 32'h210, 1, 32'h204, 5, 2, 32'hA0000001, 4));
    tbl.push_back(v(0, 0, 0, 0, 1, 1, 32'hA0000004, 0, 0, 0, 0,
                    1, 32'h204, 5, 2, 32'hA0000001, 4));
    tbl.push_back(v(0, 0, 0, 0, 1, 0, 0, 1,  0, 0, 0, 1, 32'h204, 5, 2, 32'hA0000001, 4));
    tbl.push_back(v(0, 0, 0, 0, 1, 0, 0, 1,  1, 0, 0, 1, 32'h208, 6, 2, 32'hA0000002, 3));
    tbl.push_back(v(0, 0, 0, 0, 1, 0, 0, 1,  1, 0, 0, 1, 32'h20C, 7, 2, 32'hA0000003, 2));
    tbl.push_back(v(0, 0, 0, 0, 1, 0, 0, 1,  1, 0, 0, 1, 32'h210, 8, 2, 32'hA0000004, 1));
    tbl.push_back(v(0, 0, 0, 0, 1, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0, 0, 0));

    // Reset state
    repeat (2) @(posedge clk);
    #2;
    chk_all_zero("reset");
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      string nm;
      nm = $sformatf("vec%0d", i);
      cycle_in(tbl[i].pv, tbl[i].pc, tbl[i].w, tbl[i].s, tbl[i].mrr, tbl[i].rv, tbl[i].rd,
               tbl[i].ordy, 1'b0, 1'b1);
      chk({nm, ".pc_ready"}, pc_ready, tbl[i].e_pr);
      chk({nm, ".mem_req_valid"}, mem_req_valid, tbl[i].e_mrv);
      if (tbl[i].e_mrv) chk({nm, ".mem_req_addr"}, mem_req_addr, tbl[i].e_addr);
      chk({nm, ".out_valid"}, out_valid, tbl[i].e_ov);
      if (tbl[i].e_ov) chk_head(nm, tbl[i].e_opc, tbl[i].e_ow, tbl[i].e_os, tbl[i].e_inst);
      chk({nm, ".outstanding"}, outstanding, tbl[i].e_ost);
    end

    // Backpressure: request held stable for five stalled cycles
    cycle_in(1, 32'h300, 1, 1, 0, 0, 0, 0, 0, 1);
    chk("bp.accept", pc_ready, 1'b1);
    for (int k = 0; k < 5; k++) begin
      cycle_in(1, 32'h304, 2, 2, 0, 0, 0, 0, 0, 1);
      chk("bp.hold_valid", mem_req_valid, 1'b1);
      chk("bp.hold_addr", mem_req_addr, 32'h300);
      chk("bp.pc_ready", pc_ready, 1'b0);
    end
    idle(0, 0, 0);
    chk("bp.xfer_valid", mem_req_valid, 1'b1);
    chk("bp.xfer_addr", mem_req_addr, 32'h300);
    idle(0, 0, 0);
    chk("bp.released", mem_req_valid, 1'b0);
    idle(1, 32'h12345678, 0);
    chk("bp.no_out_yet", out_valid, 1'b0);
    idle(0, 0, 1);
    chk_head("bp", 32'h300, 1, 1, 32'h12345678);
    idle(0, 0, 0);
    chk("bp.drained", outstanding, 3'd0);

    // Flush with three transferred, one answered, one still pending issue
    cycle_in(1, 32'h400, 1, 0, 1, 0, 0, 0, 0, 1);
    chk("fl.acc0", pc_ready, 1'b1);
    cycle_in(1, 32'h404, 1, 0, 1, 0, 0, 0, 0, 1);
    chk("fl.req0", mem_req_addr, 32'h400);
    cycle_in(1, 32'h408, 1, 0, 1, 1, 32'hF00D0000, 0, 0, 1);
    chk("fl.ost2", outstanding, 3'd2);
    cycle_in(1, 32'h40C, 1, 0, 1, 0, 0, 0, 0, 1);
    chk("fl.acc3", pc_ready, 1'b1);
    chk_head("fl.pre", 32'h400, 1, 0, 32'hF00D0000);
    cycle_in(0, 0, 0, 0, 0, 0, 0, 1, 1, 1);
    chk("fl.pc_ready_in_flush", pc_ready, 1'b0);
    chk("fl.pending_req", mem_req_valid, 1'b1);
    chk("fl.ost4", outstanding, 3'd4);
    idle(1, 32'hBAD00001, 1);
    chk("fl.empty", out_valid, 1'b0);
    chk("fl.drop2", outstanding, 3'd2);
    chk("fl.req_withdrawn", mem_req_valid, 1'b0);
    idle(1, 32'hBAD00002, 1);
    chk("fl.drop1", outstanding, 3'd1);
    chk("fl.dropped_a", out_valid, 1'b0);
    idle(0, 0, 1);
    chk("fl.drop0", outstanding, 3'd0);
    chk("fl.dropped_b", out_valid, 1'b0);
    cycle_in(1, 32'h500, 9, 3, 1, 0, 0, 0, 0, 1);
    chk("fl.new_acc", pc_ready, 1'b1);
    idle(0, 0, 0);
    chk("fl.new_addr", mem_req_addr, 32'h500);
    idle(1, 32'hCAFEF00D, 0);
    idle(0, 0, 1);
    chk_head("fl.new", 32'h500, 9, 3, 32'hCAFEF00D);
    idle(0, 0, 0);
    chk("fl.new_drained", outstanding, 3'd0);

    // rdy low for four cycles while a response arrives
    cycle_in(1, 32'h600, 10, 4, 1, 0, 0, 0, 0, 1);
    idle(0, 0, 0);
    chk("rdy.req", mem_req_valid, 1'b1);
    for (int k = 0; k < 4; k++) begin
      cycle_in(1, 32'h604, 11, 5, 1, (k == 1), 32'h60000000, 1, 0, 0);
      chk("rdy.no_accept", pc_ready, 1'b0);
      chk("rdy.ost_hold", outstanding, 3'd1);
      chk("rdy.capture", out_valid, (k >= 2));
    end
    cycle_in(1, 32'h604, 11, 5, 1, 0, 0, 1, 0, 1);
    chk("rdy.resume_accept", pc_ready, 1'b1);
    chk_head("rdy.resume", 32'h600, 10, 4, 32'h60000000);
    idle(0, 0, 0);
    chk("rdy.net_ost", outstanding, 3'd1);
    chk("rdy.next_addr", mem_req_addr, 32'h604);
    chk("rdy.popped", out_valid, 1'b0);
    idle(1, 32'h60400000, 0);
    idle(0, 0, 1);
    chk_head("rdy.second", 32'h604, 11, 5, 32'h60400000);
    idle(0, 0, 0);

    // Asynchronous reset mid-operation
    cycle_in(1, 32'h700, 1, 1, 1, 0, 0, 0, 0, 1);
    cycle_in(1, 32'h704, 1, 1, 1, 0, 0, 0, 0, 1);
    cycle_in(1, 32'h708, 1, 1, 1, 0, 0, 0, 0, 1);
    cycle_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    chk("ar.pre_ost", outstanding, 3'd3);
    chk("ar.pre_req", mem_req_valid, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    chk_all_zero("ar");
    @(negedge clk);
    rst = 1'b0;
    cycle_in(1, 32'h100, 3, 1, 1, 0, 0, 0, 0, 1);
    chk("ar.acc", pc_ready, 1'b1);
    idle(0, 0, 0);
    chk("ar.req", mem_req_valid, 1'b1);
    chk("ar.addr", mem_req_addr, 32'h100);
    idle(0, 0, 0);
    idle(1, 32'hDEADBEEF, 0);
    chk("ar.no_out", out_valid, 1'b0);
    idle(0, 0, 1);
    chk_head("ar", 32'h100, 3, 1, 32'hDEADBEEF);
    idle(0, 0, 0);
    chk("ar.drained", outstanding, 3'd0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/gelato_inst_fetch_pipe.md
Name: gelato_inst_fetch_pipe

Overview:
- Parametrised, pipelined successor of the single-request instruction fetch stage. Sits between the fetch scheduler (PC table) and the I-buffer/decoder.
- Keeps up to MAX_OUTSTANDING I-cache requests in flight and carries each request's warp/split metadata alongside it.
- Returns fetched instructions in order through a ready/valid output. A flush drops all queued and in-flight work, e.g. on a branch redirect.

Parameters:
PC_WIDTH, 32, PC and I-cache address width
INST_WIDTH, 32, instruction word width
WARP_NUM_WIDTH, 5, warp index width
SPLIT_NUM_WIDTH, 4, split-table index width
MAX_OUTSTANDING, 4, max accepted-but-not-delivered fetches; power of two, >=2

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
rdy  in  1  global enable; 0 freezes accept, issue and output pop
flush  in  1  drop all queued and in-flight fetches
pc_valid  in  1  scheduler offers a fetch
pc_ready  out  1  fetch accepted when pc_valid&&pc_ready&&rdy
pc  in  PC_WIDTH  fetch address
pc_warp_num  in  WARP_NUM_WIDTH  warp index
pc_split_table_num  in  SPLIT_NUM_WIDTH  split-table index
mem_req_valid  out  1  I-cache request valid (registered)
mem_req_ready  in  1  I-cache accepts; transfer when valid&&ready&&rdy
mem_req_addr  out  PC_WIDTH  request address
mem_rsp_valid  in  1  in-order response, no backpressure
mem_rsp_data  in  INST_WIDTH  response data
out_valid  out  1  instruction available
out_ready  in  1  I-buffer pops when out_valid&&out_ready&&rdy
out_pc  out  PC_WIDTH  PC of head instruction
out_warp_num  out  WARP_NUM_WIDTH  warp of head instruction
out_split_table_num  out  SPLIT_NUM_WIDTH  split index of head instruction
out_inst  out  INST_WIDTH  instruction word
outstanding  out  $clog2(MAX_OUTSTANDING)+1  current credit usage

Behaviour:
- Reset (async, rst=1): all outputs 0. Queues, counters and drop_cnt cleared. pc_ready=0 while rst is high.
- Storage:
  - Metadata FIFO (pc/warp/split), depth MAX_OUTSTANDING, written on accept.
  - Data FIFO, same depth, written on a response that is not dropped.
  - Both are circular, with pointers wrapping modulo depth.
- Credits:
  - used = meta_count + drop_cnt.
  - pc_ready = !rst && !flush && rdy && used<MAX_OUTSTANDING && (!mem_req_valid || mem_req_ready).
  - outstanding = used.
- Issue: accept in cycle N gives mem_req_valid=1 and mem_req_addr=pc in N+1. Both are held stable until transferred. Back-to-back accepts are allowed when mem_req_ready=1.
- Responses:
  - Captured every cycle regardless of rdy.
  - If drop_cnt>0, drop_cnt decrements and the data is discarded.
  - Otherwise data is written to the data FIFO. out_valid rises the next cycle.
  - Responses arrive in request order, so data head pairs with metadata head.
- Output: out_valid = data FIFO non-empty. out_* are read combinationally from the FIFO heads. A pop removes both heads and frees one credit in the same cycle.
- Flush (acts in the cycle asserted, regardless of rdy):
  - Meta and data FIFOs are emptied.
  - A pending mem_req_valid is deasserted next cycle, as the only permitted withdrawal of a request.
  - drop_cnt <= (requests transferred, minus responses received, counting any response in the flush cycle as dropped).
  - pc_ready=0 during flush.
  - A pop in the same cycle as flush is discarded.
- Simultaneous accept+pop at used==MAX_OUTSTANDING: not allowed, because pc_ready uses the registered count. Accept+pop below full: net used unchanged.
- rdy=0: no accept, issue transfer or pop; all registers hold except response capture and flush.
- Response with no request outstanding: illegal; the assertion fires in simulation ($error).
- Latency: accept to mem_req_valid is 1 cycle; response to out_valid is 1 cycle.

Test Plan:
- Single fetch, mem_req_ready=1: pc=0x100, warp 3, split 1 at cycle 0. mem_req_valid/addr=0x100 at cycle 1. Response 0xDEADBEEF at cycle 3 gives out_valid at 4 with pc 0x100, warp 3, split 1, inst 0xDEADBEEF.
- Saturation: 6 back-to-back fetches, out_ready=0, responses immediate. Exactly 4 accepted, pc_ready=0 with outstanding=4. One pop re-enables exactly one accept.
- Backpressure: mem_req_ready=0 for 5 cycles. mem_req_addr stays stable and pc_ready=0. The transfer completes on the first ready cycle.
- Flush mid-flight: 3 requests transferred, 1 response returned, then flush. FIFOs empty, drop_cnt=2. The next 2 responses never reach the output. A new fetch after flush is delivered correctly.
- rdy=0 for 4 cycles while a response arrives. The response is captured; no pop or accept happens until rdy=1.
- Async reset asserted mid-operation (outstanding=3, mem_req_valid=1). All outputs are 0 immediately, and the next fetch after rst=0 behaves as in the single-fetch case.
